// File: rtl/pwm_multi_speed.sv
// pwm_multi_speed: N-channel motor PWM sharing one period counter, with double-buffered duty, slew limiting and per-channel polarity
module pwm_multi_speed #(
    parameter int                NUM_CH    = 4,
    parameter int                CMD_W     = 8,
    parameter int                CNT_W     = 10,
    parameter int                PERIOD    = 606,
    parameter int                SCALE     = 3,
    parameter int                CMD_MAX   = 200,
    parameter int                SLEW_STEP = 0,
    parameter logic [NUM_CH-1:0] POLARITY  = {NUM_CH{1'b1}},
    localparam int               CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [CMD_W-1:0]  cmd_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start
);
    localparam int PW = CMD_W + CNT_W;
    localparam logic [CNT_W:0] STEP = (CNT_W + 1)'(SLEW_STEP);
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  shadow [NUM_CH];
    logic [CNT_W-1:0]  active [NUM_CH];
    logic [CNT_W-1:0]  act_next [NUM_CH];
    logic [NUM_CH-1:0] up, dn, raw;
    logic [PW-1:0]     prod;
    logic [CNT_W-1:0]  target;
    logic              accept, ch_ok, boundary;

    // The product is formed wide enough that it can never wrap before clipping to a full period.
    assign prod     = PW'(cmd_data) * PW'(SCALE);
    assign target   = (PW'(cmd_data) >= PW'(CMD_MAX)) ? '0
                    : (prod > PW'(PERIOD + 1)) ? CNT_W'(PERIOD + 1) : prod[CNT_W-1:0];
    assign ch_ok    = {1'b0, cmd_ch} < (CH_W + 1)'(NUM_CH);
    assign accept   = cmd_valid && cmd_ready;
    assign boundary = enable && (cnt == CNT_W'(PERIOD));

    // Next active match: jump straight to shadow, or step toward it by at most STEP per period.
    always_comb begin
        up  = '0;
        dn  = '0;
        raw = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            up[i]       = {1'b0, shadow[i]} > {1'b0, active[i]} + STEP;
            dn[i]       = {1'b0, active[i]} > {1'b0, shadow[i]} + STEP;
            act_next[i] = (SLEW_STEP == 0 || !(up[i] || dn[i])) ? shadow[i]
                        : up[i] ? active[i] + STEP[CNT_W-1:0] : active[i] - STEP[CNT_W-1:0];
            raw[i]      = enable && (cnt < active[i]);
        end
    end

    // Shared period counter; parked at 0 while disabled so a re-enable starts a fresh period.
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else     cnt <= (enable && cnt != CNT_W'(PERIOD)) ? cnt + 1'b1 : '0;
    end

    // Shadow duty registers written by accepted commands; out-of-range channels are dropped.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst)                                      shadow[i] <= '0;
            else if (accept && ch_ok && cmd_ch == CH_W'(i)) shadow[i] <= target;
        end
    end

    // Active matches change only at the period boundary (or freely while idle), so no runt pulses.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst)           active[i] <= '0;
            else if (!enable)  active[i] <= shadow[i];
            else if (boundary) active[i] <= act_next[i];
        end
    end

    // Registered outputs: compare result with polarity applied, period marker and handshake ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out      <= ~POLARITY;
            period_start <= 1'b0;
            cmd_ready    <= 1'b0;
        end else begin
            pwm_out      <= ~(raw ^ POLARITY);
            period_start <= enable && (cnt == '0);
            cmd_ready    <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pwm_multi_speed.sv
// tb_pwm_multi_speed: checks three PWM configurations against a cycle model plus spec-derived duty widths
module tb_pwm_multi_speed;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, enable = 1'b0, cmd_valid = 1'b0;
    logic [2:0] cmd_ch = '0;
    logic [7:0] cmd_data = '0;
    logic       r0, r1, r2, ps0, ps1, ps2;
    logic [3:0] pw0, pw1;
    logic [4:0] pw2;

    pwm_multi_speed u0 (.clk(clk), .rst(rst), .enable(enable), .cmd_valid(cmd_valid), .cmd_ready(r0),
                        .cmd_ch(cmd_ch[1:0]), .cmd_data(cmd_data), .pwm_out(pw0), .period_start(ps0));
    pwm_multi_speed #(.SLEW_STEP(100), .POLARITY(4'b0111)) u1 (.clk(clk), .rst(rst), .enable(enable),
                        .cmd_valid(cmd_valid), .cmd_ready(r1), .cmd_ch(cmd_ch[1:0]), .cmd_data(cmd_data),
                        .pwm_out(pw1), .period_start(ps1));
    pwm_multi_speed #(.NUM_CH(5), .SCALE(4)) u2 (.clk(clk), .rst(rst), .enable(enable), .cmd_valid(cmd_valid),
                        .cmd_ready(r2), .cmd_ch(cmd_ch), .cmd_data(cmd_data), .pwm_out(pw2), .period_start(ps2));

    localparam int PER = 606;
    int         nch [3] = '{4, 4, 5};
    int         scl [3] = '{3, 3, 4};
    int         slw [3] = '{0, 100, 0};
    logic [4:0] pol [3] = '{5'b01111, 5'b00111, 5'b11111};
    int         m_cnt [3];
    int         m_sh [3][5];
    int         m_act [3][5];
    logic [4:0] m_out [3];
    logic       m_ps [3];
    logic       m_rdy [3];
    int         errors = 0, checks = 0, mm = 0;
    logic [18:0] last_got, last_exp;

    // Behavioural model: one step of the spec rules per clock, in plain integers.
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int  ch, d;
            logic acc;
            ch  = (k < 2) ? int'(cmd_ch[1:0]) : int'(cmd_ch);
            acc = cmd_valid && m_rdy[k];
            if (rst) begin
                m_cnt[k] = 0;
                for (int i = 0; i < 5; i++) begin m_sh[k][i] = 0; m_act[k][i] = 0; end
                m_out[k] = ~pol[k]; m_ps[k] = 1'b0; m_rdy[k] = 1'b0;
            end else begin
                for (int i = 0; i < nch[k]; i++)
                    m_out[k][i] = (enable && m_cnt[k] < m_act[k][i]) ? pol[k][i] : !pol[k][i];
                m_ps[k] = enable && m_cnt[k] == 0;
                for (int i = 0; i < nch[k]; i++) begin
                    d = m_sh[k][i] - m_act[k][i];
                    if (!enable) m_act[k][i] = m_sh[k][i];
                    else if (m_cnt[k] == PER) begin
                        if (slw[k] == 0)        m_act[k][i] = m_sh[k][i];
                        else if (d > slw[k])    m_act[k][i] += slw[k];
                        else if (d < -slw[k])   m_act[k][i] -= slw[k];
                        else                    m_act[k][i] = m_sh[k][i];
                    end
                end
                m_cnt[k] = (enable && m_cnt[k] != PER) ? m_cnt[k] + 1 : 0;
                if (acc && ch < nch[k])
                    m_sh[k][ch] = (cmd_data >= 200) ? 0 : ((int'(cmd_data) * scl[k] > PER + 1) ? PER + 1 : int'(cmd_data) * scl[k]);
                m_rdy[k] = 1'b1;
            end
        end
    endtask

    // Advance one clock, step the model, and log any difference between DUTs and model.
    task automatic cyc();
        logic [18:0] got, exp;
        @(posedge clk);
        model_step();
        @(negedge clk);
        got = {pw2, ps2, r2, pw1, ps1, r1, pw0, ps0, r0};
        exp = {m_out[2], m_ps[2], m_rdy[2], m_out[1][3:0], m_ps[1], m_rdy[1], m_out[0][3:0], m_ps[0], m_rdy[0]};
        if (got !== exp) begin last_got = got; last_exp = exp; mm++; end
    endtask

    task automatic wr(input int ch, input int d);
        cmd_valid = 1'b1; cmd_ch = 3'(ch); cmd_data = 8'(d);
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_ps(input string tag);
        int k;
        k = 0;
        do begin cyc(); k++; end while (!ps0 && k < 2000);
        checks++;
        if (!ps0) begin errors++; $display("FAIL %s period_start timeout: none in %0d cycles, required within 607", tag, k); end
    endtask

    // Collect one period-long window of samples; optionally issue a write partway through.
    task automatic measure(input bit first_cur, input int ch, input int wr_at, input int wr_ch, input int wr_d,
                           output int h0, output int l1, output int h2, output int p0, output logic st);
        h0 = 0; l1 = 0; h2 = 0; p0 = 0; st = 1'b0;
        for (int j = 0; j <= PER; j++) begin
            if (j > 0 || !first_cur) cyc();
            if (j == 0) st = ps0 && pw0[ch];
            h0 += int'(pw0[ch]); l1 += int'(!pw1[ch]); h2 += int'(pw2[ch]); p0 += int'(ps0);
            cmd_valid = (j == wr_at); cmd_ch = 3'(wr_ch); cmd_data = 8'(wr_d);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        int h0, l1, h2, p0, mm0;
        logic st;
        logic [18:0] v;
        mm0 = mm;
        rst = 1'b1; enable = 1'b1; cmd_valid = 1'b1; cmd_ch = 3'd0; cmd_data = 8'd100;
        repeat (3) begin
            cyc();
            v = {r0, r1, r2, ps0, ps1, ps2, pw0, pw1, pw2};
            checks++;
            if (v !== 19'b000000_0000_1000_00000) begin errors++; $display("FAIL reset_outputs: got %h expected %h", v, 19'b000000_0000_1000_00000); end
        end
        rst = 1'b0; cmd_valid = 1'b0;
        cyc();
        checks++;
        if ({r0, r1, r2} !== 3'b111) begin errors++; $display("FAIL ready_after_reset: got %b expected 111", {r0, r1, r2}); end
        measure(1'b1, 0, -1, 0, 0, h0, l1, h2, p0, st);
        checks++;
        if (h0 !== 0 || p0 !== 1) begin errors++; $display("FAIL reset_nothing_stored: high=%0d starts=%0d expected 0 and 1", h0, p0); end
        checks++;
        if (mm != mm0) begin errors++; $display("FAIL reset_lockstep: %0d cycles differ, got %h expected %h", mm - mm0, last_got, last_exp); end
    endtask

    task automatic test_basic_duty();
        int h0, l1, h2, p0, mm0;
        logic st;
        mm0 = mm;
        wr(0, 100);
        wait_ps("basic");
        measure(1'b1, 0, -1, 0, 0, h0, l1, h2, p0, st);
        checks++;
        if (h0 !== 300) begin errors++; $display("FAIL basic_width: got %0d expected 300", h0); end
        checks++;
        if (p0 !== 1 || st !== 1'b1) begin errors++; $display("FAIL basic_period_start: count=%0d at_edge=%b expected 1 and 1", p0, st); end
        checks++;
        if (h2 !== 400) begin errors++; $display("FAIL basic_scale4_width: got %0d expected 400", h2); end
        checks++;
        if (mm != mm0) begin errors++; $display("FAIL basic_lockstep: %0d cycles differ, got %h expected %h", mm - mm0, last_got, last_exp); end
    endtask

    task automatic test_boundary_write();
        int h0, l1, h2, p0, mm0;
        logic st;
        mm0 = mm;
        wr(1, 50);
        wait_ps("bnd0");
        wait_ps("bnd1");
        repeat (PER - 1) cyc();
        wr(1, 10);
        wait_ps("bnd2");
        measure(1'b1, 1, -1, 1, 0, h0, l1, h2, p0, st);
        checks++;
        if (h0 !== 150) begin errors++; $display("FAIL boundary_old_duty: got %0d expected 150", h0); end
        measure(1'b0, 1, 300, 1, 20, h0, l1, h2, p0, st);
        checks++;
        if (h0 !== 30) begin errors++; $display("FAIL boundary_new_duty: got %0d expected 30", h0); end
        measure(1'b0, 1, -1, 1, 0, h0, l1, h2, p0, st);
        checks++;
        if (h0 !== 60) begin errors++; $display("FAIL midperiod_write_next: got %0d expected 60", h0); end
        checks++;
        if (mm != mm0) begin errors++; $display("FAIL boundary_lockstep: %0d cycles differ, got %h expected %h", mm - mm0, last_got, last_exp); end
    endtask

    task automatic test_saturation();
        int h0, l1, h2, p0, mm0;
        logic st;
        int cmd [3] = '{200, 199, 190};
        int e0 [3]  = '{0, 597, 570};
        int e2 [3]  = '{0, 607, 607};
        mm0 = mm;
        for (int t = 0; t < 3; t++) begin
            wr(2, cmd[t]);
            wait_ps("sat");
            measure(1'b1, 2, -1, 0, 0, h0, l1, h2, p0, st);
            checks++;
            if (h0 !== e0[t] || h2 !== e2[t])
                begin errors++; $display("FAIL saturation cmd=%0d: scale3=%0d scale4=%0d expected %0d and %0d", cmd[t], h0, h2, e0[t], e2[t]); end
        end
        checks++;
        if (mm != mm0) begin errors++; $display("FAIL saturation_lockstep: %0d cycles differ, got %h expected %h", mm - mm0, last_got, last_exp); end
    endtask

    task automatic test_slew_polarity();
        int h0, l1, h2, p0, mm0;
        logic st;
        int ramp [10] = '{100, 200, 300, 400, 450, 350, 250, 150, 50, 0};
        mm0 = mm;
        for (int dir = 0; dir < 2; dir++) begin
            wr(3, dir == 0 ? 150 : 0);
            wait_ps("slew");
            for (int p = 0; p < 5; p++) begin
                measure(p == 0, 3, -1, 0, 0, h0, l1, h2, p0, st);
                checks++;
                if (l1 !== ramp[dir * 5 + p]) begin errors++; $display("FAIL slew_low_width step %0d: got %0d expected %0d", dir * 5 + p, l1, ramp[dir * 5 + p]); end
                if (p == 0) begin
                    checks++;
                    if (h0 !== (dir == 0 ? 450 : 0)) begin errors++; $display("FAIL no_slew_width dir %0d: got %0d expected %0d", dir, h0, dir == 0 ? 450 : 0); end
                end
            end
        end
        checks++;
        if (mm != mm0) begin errors++; $display("FAIL slew_lockstep: %0d cycles differ, got %h expected %h", mm - mm0, last_got, last_exp); end
    endtask

    task automatic test_dropped_and_last_write();
        int h0, l1, h2, p0, mm0;
        logic st;
        mm0 = mm;
        wr(5, 150); wr(6, 150); wr(7, 150);
        wait_ps("drop");
        measure(1'b1, 3, -1, 0, 0, h0, l1, h2, p0, st);
        checks++;
        if (h2 !== 0 || h0 !== 450) begin errors++; $display("FAIL dropped_ch: ch3 5ch=%0d 4ch=%0d expected 0 and 450", h2, h0); end
        measure(1'b0, 4, -1, 0, 0, h0, l1, h2, p0, st);
        checks++;
        if (h2 !== 0) begin errors++; $display("FAIL dropped_ch4: got %0d expected 0", h2); end
        wr(1, 30); wr(1, 40);
        wait_ps("last");
        measure(1'b1, 1, -1, 0, 0, h0, l1, h2, p0, st);
        checks++;
        if (h0 !== 120 || h2 !== 160) begin errors++; $display("FAIL last_write_wins: got %0d and %0d expected 120 and 160", h0, h2); end
        checks++;
        if (mm != mm0) begin errors++; $display("FAIL drop_lockstep: %0d cycles differ, got %h expected %h", mm - mm0, last_got, last_exp); end
    endtask

    task automatic test_enable_toggle();
        int h0, l1, h2, p0, mm0;
        logic st;
        logic [13:0] v;
        mm0 = mm;
        wait_ps("en");
        repeat (249) cyc();
        enable = 1'b0;
        cyc();
        v = {pw0, pw1, pw2, ps0};
        checks++;
        if (v !== 14'b0000_1000_00000_0) begin errors++; $display("FAIL disable_idle: got %b expected %b", v, 14'b0000_1000_00000_0); end
        wr(0, 150);
        repeat (5) cyc();
        v = {pw0, pw1, pw2, ps0};
        checks++;
        if (v !== 14'b0000_1000_00000_0) begin errors++; $display("FAIL disabled_hold: got %b expected %b", v, 14'b0000_1000_00000_0); end
        enable = 1'b1;
        cyc();
        checks++;
        if (ps0 !== 1'b1 || pw0[0] !== 1'b1) begin errors++; $display("FAIL reenable_start: ps=%b out=%b expected 1 and 1", ps0, pw0[0]); end
        measure(1'b1, 0, -1, 0, 0, h0, l1, h2, p0, st);
        checks++;
        if (h0 !== 450 || p0 !== 1) begin errors++; $display("FAIL reenable_duty: width=%0d starts=%0d expected 450 and 1", h0, p0); end
        checks++;
        if (l1 !== 157) begin errors++; $display("FAIL reenable_slew_bypass: low=%0d expected 157", l1); end
        checks++;
        if (mm != mm0) begin errors++; $display("FAIL enable_lockstep: %0d cycles differ, got %h expected %h", mm - mm0, last_got, last_exp); end
    endtask

    initial begin
        test_reset();
        test_basic_duty();
        test_boundary_write();
        test_saturation();
        test_slew_polarity();
        test_dropped_and_last_write();
        test_enable_toggle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
